// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and default widths for the two-requester SRAM port arbiter.
package sram_port_arbiter_pkg;

    localparam int unsigned SPA_ADDR_WIDTH = 10;
    localparam int unsigned SPA_DATA_WIDTH = 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_SERVE = 1'b1
    } state_e;

    typedef struct packed {
        logic                      w;
        logic [SPA_ADDR_WIDTH-1:0] addr;
        logic [SPA_DATA_WIDTH-1:0] data;
        logic                      mask;
    } req_t;

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-input round-robin arbiter; the priority pointer flips to the loser after every grant.
module sram_rr_arb2 (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] grant_o,
    output logic       grant_v_o
);

    logic prio_q, prio_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

    always_comb begin
        grant_o = 2'b00;
        if (en_i) begin
            case (req_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = prio_q ? 2'b10 : 2'b01;
                default: grant_o = 2'b00;
            endcase
        end
        grant_v_o = |grant_o;
        prio_d    = grant_v_o ? ~grant_o[1] : prio_q;
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares the RW port of an external single-RW/single-R SRAM macro between two requesters,
// optionally zero-filling the macro after reset before serving requests.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = SPA_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = SPA_DATA_WIDTH,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [1:0]                     v_i,
    input  logic [1:0]                     w_i,
    input  logic [1:0][ADDR_WIDTH-1:0]     addr_i,
    input  logic [1:0][DATA_WIDTH-1:0]     data_i,
    input  logic [1:0]                     mask_i,
    output logic [1:0]                     yumi_o,
    output logic [1:0]                     rv_o,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    output logic                           ready_o,
    output logic                           csb0_o,
    output logic                           web0_o,
    output logic                           wmask0_o,
    output logic [ADDR_WIDTH-1:0]          addr0_o,
    output logic [DATA_WIDTH-1:0]          din0_o,
    input  logic [DATA_WIDTH-1:0]          dout0_i,
    output logic                           csb1_o,
    output logic [ADDR_WIDTH-1:0]          addr1_o
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic [1:0]            rv_q, rv_d;
    logic [1:0]            grant;
    logic                  grant_v;
    logic                  g_idx;
    logic                  serve;

    assign serve = (state_q == ST_SERVE) && !reset_i;
    assign g_idx = grant[1];

    sram_rr_arb2 u_arb (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .en_i      (serve),
        .req_i     (v_i),
        .grant_o   (grant),
        .grant_v_o (grant_v)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_SERVE;
            clr_cnt_q <= '0;
            rv_q      <= 2'b00;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rv_q      <= rv_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        rv_d      = 2'b00;
        csb0_o    = 1'b1;
        web0_o    = 1'b1;
        wmask0_o  = 1'b0;
        addr0_o   = '0;
        din0_o    = '0;
        yumi_o    = grant;

        case (state_q)
            ST_CLEAR: begin
                if (!reset_i) begin
                    csb0_o   = 1'b0;
                    web0_o   = 1'b0;
                    wmask0_o = 1'b1;
                    addr0_o  = clr_cnt_q;
                end
                // Counter saturates at the last address; the state change ends the fill.
                if (clr_cnt_q == '1) begin
                    state_d = ST_SERVE;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                end
            end
            ST_SERVE: begin
                if (grant_v) begin
                    csb0_o   = 1'b0;
                    web0_o   = ~w_i[g_idx];
                    wmask0_o = mask_i[g_idx];
                    addr0_o  = addr_i[g_idx];
                    din0_o   = data_i[g_idx];
                    rv_d     = w_i[g_idx] ? 2'b00 : grant;
                end
            end
        endcase
    end

    // Response gated by reset so a read granted just before reset never reports.
    assign rv_o    = reset_i ? 2'b00 : rv_q;
    assign rdata_o = (|rv_o) ? dout0_i : '0;
    assign ready_o = serve;
    assign csb1_o  = 1'b1;
    assign addr1_o = '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized + directed bench for sram_port_arbiter with a behavioural macro and a scoreboard.
module tb_sram_port_arbiter;
    import sram_port_arbiter_pkg::*;

    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 8;
    localparam int          DEPTH = 1024;

    logic                   clk_i = 1'b0;
    logic                   reset_i;
    logic [1:0]             v_i, w_i, mask_i;
    logic [1:0][AW-1:0]     addr_i;
    logic [1:0][DW-1:0]     data_i;
    logic [1:0]             yumi_o, rv_o;
    logic [DW-1:0]          rdata_o;
    logic                   ready_o, csb0_o, web0_o, wmask0_o, csb1_o;
    logic [AW-1:0]          addr0_o, addr1_o;
    logic [DW-1:0]          din0_o, dout0_i;

    sram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_ON_RESET(1'b1)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .w_i(w_i), .addr_i(addr_i),
        .data_i(data_i), .mask_i(mask_i), .yumi_o(yumi_o), .rv_o(rv_o), .rdata_o(rdata_o),
        .ready_o(ready_o), .csb0_o(csb0_o), .web0_o(web0_o), .wmask0_o(wmask0_o),
        .addr0_o(addr0_o), .din0_o(din0_o), .dout0_i(dout0_i), .csb1_o(csb1_o),
        .addr1_o(addr1_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural macro: registered read, masked write, powered up with garbage.
    logic [DW-1:0] macro_mem [DEPTH];
    logic [DW-1:0] macro_dout;
    initial for (int i = 0; i < DEPTH; i++) macro_mem[i] = DW'($urandom);
    always @(posedge clk_i) begin
        if (!csb0_o) begin
            if (!web0_o) begin
                if (wmask0_o) macro_mem[addr0_o] <= din0_o;
            end else begin
                macro_dout <= macro_mem[addr0_o];
            end
        end
    end
    assign dout0_i = macro_dout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int           due;
        logic [1:0]   rv;
        logic [DW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: clear phase length, alternating priority, word memory.
    logic [DW-1:0] ref_mem [DEPTH];
    int m_cnt  = 0;
    int m_prio = 0;

    always @(negedge clk_i) begin
        int   g;
        exp_t e;
        chk("csb1", 32'(csb1_o), 32'd1);
        chk("addr1", 32'(addr1_o), 32'd0);
        if (reset_i) begin
            chk("rst_yumi", 32'(yumi_o), 32'd0);
            chk("rst_csb0", 32'(csb0_o), 32'd1);
            chk("rst_ready", 32'(ready_o), 32'd0);
            m_prio = 0;
            m_cnt  = 0;
        end else if (m_cnt < DEPTH) begin
            chk("clr_ready", 32'(ready_o), 32'd0);
            chk("clr_yumi", 32'(yumi_o), 32'd0);
            chk("clr_csb0", 32'(csb0_o), 32'd0);
            chk("clr_web0", 32'(web0_o), 32'd0);
            chk("clr_wmask", 32'(wmask0_o), 32'd1);
            chk("clr_addr", 32'(addr0_o), 32'(m_cnt));
            chk("clr_din", 32'(din0_o), 32'd0);
            m_cnt++;
            if (m_cnt == DEPTH) for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        end else begin
            chk("ready", 32'(ready_o), 32'd1);
            case (v_i)
                2'b01:   g = 0;
                2'b10:   g = 1;
                2'b11:   g = m_prio;
                default: g = -1;
            endcase
            if (g < 0) begin
                chk("idle_yumi", 32'(yumi_o), 32'd0);
                chk("idle_csb0", 32'(csb0_o), 32'd1);
                chk("idle_addr0", 32'(addr0_o), 32'd0);
            end else begin
                chk("yumi", 32'(yumi_o), 32'(1 << g));
                chk("csb0", 32'(csb0_o), 32'd0);
                chk("web0", 32'(!w_i[g]), 32'(web0_o));
                chk("addr0", 32'(addr0_o), 32'(addr_i[g]));
                if (w_i[g]) begin
                    chk("wmask0", 32'(wmask0_o), 32'(mask_i[g]));
                    chk("din0", 32'(din0_o), 32'(data_i[g]));
                    if (mask_i[g]) ref_mem[addr_i[g]] = data_i[g];
                end else begin
                    e.due  = cyc + 1;
                    e.rv   = 2'(1 << g);
                    e.data = ref_mem[addr_i[g]];
                    exp_q.push_back(e);
                end
                m_prio = (g == 0) ? 1 : 0;
            end
        end
    end

    // Monitor: pops expected read responses when they fall due.
    always @(negedge clk_i) begin
        exp_t e;
        if (reset_i) begin
            chk("rst_rv", 32'(rv_o), 32'd0);
            exp_q.delete();
        end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            chk("rv", 32'(rv_o), 32'(e.rv));
            chk("rdata", 32'(rdata_o), 32'(e.data));
        end else begin
            chk("rv_idle", 32'(rv_o), 32'd0);
            chk("rdata_idle", 32'(rdata_o), 32'd0);
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input req_t r0, input req_t r1);
        v_i       = v;
        w_i       = {r1.w, r0.w};
        addr_i[0] = r0.addr;
        addr_i[1] = r1.addr;
        data_i[0] = r0.data;
        data_i[1] = r1.data;
        mask_i    = {r1.mask, r0.mask};
        step();
    endtask

    task automatic idle(input int n);
        req_t z;
        z = '0;
        for (int i = 0; i < n; i++) drive(2'b00, z, z);
    endtask

    task automatic pulse_reset();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
    endtask

    req_t rq0, rq1, rz;
    int   found;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rz      = '0;
        reset_i = 1'b1;
        v_i = '0; w_i = '0; mask_i = '0; addr_i = '0; data_i = '0;
        step();
        step();
        reset_i = 1'b0;

        // Full clear, then idle.
        idle(DEPTH + 6);

        // Reset in the middle of a clear restarts it from address 0.
        pulse_reset();
        found = 0;
        for (int i = 0; i < 1100 && found == 0; i++) begin
            @(negedge clk_i);
            if (!csb0_o && addr0_o == 10'd500) found = 1;
        end
        chk("find_addr500", 32'(found), 32'd1);
        step();
        pulse_reset();
        @(negedge clk_i);
        chk("clear_restart", 32'(addr0_o), 32'd0);
        step();
        idle(DEPTH + 4);

        // Both requesters valid continuously: strict alternation.
        rq0 = '{w: 1'b0, addr: 10'h001, data: 8'h00, mask: 1'b0};
        rq1 = '{w: 1'b0, addr: 10'h002, data: 8'h00, mask: 1'b0};
        for (int i = 0; i < 8; i++) drive(2'b11, rq0, rq1);
        idle(2);

        // Write then immediately read the top word.
        rq0 = '{w: 1'b1, addr: 10'h3FF, data: 8'hA5, mask: 1'b1};
        drive(2'b01, rq0, rz);
        rq0 = '{w: 1'b0, addr: 10'h3FF, data: 8'h00, mask: 1'b0};
        drive(2'b01, rq0, rz);
        @(negedge clk_i);
        chk("a5_readback", 32'(rdata_o), 32'h0000_00A5);
        step();

        // Single read from requester 1 after a clear.
        rq1 = '{w: 1'b0, addr: 10'h010, data: 8'h00, mask: 1'b0};
        drive(2'b10, rz, rq1);
        idle(2);

        // Masked-off write leaves memory untouched.
        rq0 = '{w: 1'b1, addr: 10'h011, data: 8'h3C, mask: 1'b0};
        drive(2'b01, rq0, rz);
        rq0 = '{w: 1'b0, addr: 10'h011, data: 8'h00, mask: 1'b0};
        drive(2'b01, rq0, rz);
        idle(2);

        // Read granted, then reset next cycle: response dropped, priority back to 0.
        rq0 = '{w: 1'b0, addr: 10'h005, data: 8'h00, mask: 1'b0};
        drive(2'b01, rq0, rz);
        v_i = 2'b00;
        pulse_reset();
        idle(DEPTH + 2);
        rq1 = '{w: 1'b0, addr: 10'h006, data: 8'h00, mask: 1'b0};
        drive(2'b11, rq0, rq1);
        idle(2);

        // Randomized traffic over a small address set to force hits.
        for (int i = 0; i < 1500; i++) begin
            rq0.w    = 1'($urandom);
            rq0.addr = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom_range(0, 7));
            rq0.data = 8'($urandom);
            rq0.mask = ($urandom_range(0, 3) != 0);
            rq1.w    = 1'($urandom);
            rq1.addr = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom_range(0, 7));
            rq1.data = 8'($urandom);
            rq1.mask = ($urandom_range(0, 3) != 0);
            drive(2'($urandom), rq0, rq1);
        end
        idle(4);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
